// File: rtl/orpsoc_rst_gen_if.sv
// Reset-sequencer bundle: debug reset request in, staged resets and status out.
// The master side is the sequencer; the slave side is whatever consumes the resets.
interface orpsoc_rst_gen_if #(
  parameter int CNT_W = 8
);
  logic             dbg_rst_i;
  logic             wb_rst_o;
  logic             cpu_rst_o;
  logic             rst_done_o;
  logic [CNT_W-1:0] dbg_rst_cnt_o;

  modport master (
    input  dbg_rst_i,
    output wb_rst_o,
    output cpu_rst_o,
    output rst_done_o,
    output dbg_rst_cnt_o
  );

  modport slave (
    output dbg_rst_i,
    input  wb_rst_o,
    input  cpu_rst_o,
    input  rst_done_o,
    input  dbg_rst_cnt_o
  );
endinterface

// File: rtl/orpsoc_rst_gen.sv
// Board-level reset sequencer: synchronises release of the pad reset, holds
// both resets for a while, frees the Wishbone fabric first and the CPU later.
// A debug reset request replays the hold phase and is counted (saturating).
module orpsoc_rst_gen #(
  parameter int SYNC_STAGES      = 2,
  parameter int RST_HOLD_CYCLES  = 16,
  parameter int CPU_DELAY_CYCLES = 8,
  parameter int CNT_W            = 8
) (
  input  logic               clk_pad_i,
  input  logic               rst_n_pad_i,
  orpsoc_rst_gen_if.master   bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WB_UP = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // One shared phase counter covers both the hold and the CPU delay phases.
  localparam int CNT_MAX = (RST_HOLD_CYCLES > CPU_DELAY_CYCLES) ? RST_HOLD_CYCLES : CPU_DELAY_CYCLES;
  localparam int TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [TW-1:0]    HOLD_LAST = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    CPU_LAST  = TW'(CPU_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBG_SAT   = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("orpsoc_rst_gen: SYNC_STAGES must be >= 2");
  end
  if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("orpsoc_rst_gen: RST_HOLD_CYCLES must be >= 1");
  end
  if (CPU_DELAY_CYCLES < 1) begin : g_bad_delay
    $error("orpsoc_rst_gen: CPU_DELAY_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   wb_rst_q, wb_rst_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       dbg_cnt_q, dbg_cnt_d;
  logic                   sync_rel;

  assign sync_rel = sync_q[SYNC_STAGES-1];

  // Next-state logic: release synchroniser shift plus the sequencing FSM.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_rst_d  = wb_rst_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    dbg_cnt_d = dbg_cnt_q;

    case (state_q)
      ST_RESET: begin
        // Debug requests are meaningless until the pad release has propagated.
        if (sync_rel) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        // A debug request here only stretches the hold; it is not a new event.
        if (bus.dbg_rst_i) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = ST_WB_UP;
          cnt_d    = '0;
          wb_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_WB_UP, ST_RUN: begin
        if (bus.dbg_rst_i) begin
          // Debug reset wins over any simultaneous release step.
          state_d   = ST_HOLD;
          cnt_d     = '0;
          wb_rst_d  = 1'b1;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          if (dbg_cnt_q != DBG_SAT) begin
            dbg_cnt_d = dbg_cnt_q + CNT_W'(1);
          end
        end else if (state_q == ST_WB_UP) begin
          if (cnt_q == CPU_LAST) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State and output registers; the pad reset forces everything asynchronously.
  always_ff @(posedge clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      sync_q    <= '0;
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      wb_rst_q  <= 1'b1;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      dbg_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_rst_q  <= wb_rst_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      dbg_cnt_q <= dbg_cnt_d;
    end
  end

  assign bus.wb_rst_o      = wb_rst_q;
  assign bus.cpu_rst_o     = cpu_rst_q;
  assign bus.rst_done_o    = done_q;
  assign bus.dbg_rst_cnt_o = dbg_cnt_q;

endmodule

// File: tb/tb_orpsoc_rst_gen.sv
// Directed bench for orpsoc_rst_gen: a default instance and a CNT_W=2
// instance share clock, pad reset and debug request.
module tb_orpsoc_rst_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic dbg   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  orpsoc_rst_gen_if #(.CNT_W(8)) m_if ();
  orpsoc_rst_gen_if #(.CNT_W(2)) s_if ();

  assign m_if.dbg_rst_i = dbg;
  assign s_if.dbg_rst_i = dbg;

  orpsoc_rst_gen #(.CNT_W(8)) u_main (
    .clk_pad_i   (clk),
    .rst_n_pad_i (rst_n),
    .bus         (m_if)
  );

  orpsoc_rst_gen #(.CNT_W(2)) u_sat (
    .clk_pad_i   (clk),
    .rst_n_pad_i (rst_n),
    .bus         (s_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then sample 1ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From the current point, wb_rst_o must fall after wb_e edges and
  // cpu_rst_o fall / rst_done_o rise after cpu_e edges.
  task automatic expect_release(input string tag, input int wb_e, input int cpu_e);
    step(wb_e - 1);
    chk({tag, "_wb_pre"}, m_if.wb_rst_o, 1);
    step(1);
    chk({tag, "_wb_fall"}, m_if.wb_rst_o, 0);
    chk({tag, "_sat_wb_fall"}, s_if.wb_rst_o, 0);
    chk({tag, "_cpu_held"}, m_if.cpu_rst_o, 1);
    step(cpu_e - wb_e - 1);
    chk({tag, "_cpu_pre"}, m_if.cpu_rst_o, 1);
    chk({tag, "_done_pre"}, m_if.rst_done_o, 0);
    step(1);
    chk({tag, "_cpu_fall"}, m_if.cpu_rst_o, 0);
    chk({tag, "_done"}, m_if.rst_done_o, 1);
    $display("txn %s: wb release +%0d, cpu release +%0d edges", tag, wb_e, cpu_e);
  endtask

  // Single-cycle debug pulse sampled in WB_UP or RUN.
  task automatic dbg_pulse(input string tag, input int exp_m, input int exp_s);
    dbg = 1'b1;
    step(1);
    dbg = 1'b0;
    chk({tag, "_wb"}, m_if.wb_rst_o, 1);
    chk({tag, "_cpu"}, m_if.cpu_rst_o, 1);
    chk({tag, "_done"}, m_if.rst_done_o, 0);
    chk({tag, "_cnt"}, m_if.dbg_rst_cnt_o, exp_m);
    chk({tag, "_sat_cnt"}, s_if.dbg_rst_cnt_o, exp_s);
    $display("txn %s: debug reset, cnt=%0d sat_cnt=%0d", tag, m_if.dbg_rst_cnt_o, s_if.dbg_rst_cnt_o);
  endtask

  initial begin
    // Power-on: pad reset low for 200ns, released on a falling clock edge.
    #50;
    chk("por_wb", m_if.wb_rst_o, 1);
    chk("por_cpu", m_if.cpu_rst_o, 1);
    chk("por_done", m_if.rst_done_o, 0);
    chk("por_cnt", m_if.dbg_rst_cnt_o, 0);
    #150 rst_n = 1'b1;
    expect_release("por", 19, 27);
    chk("por_cnt_after", m_if.dbg_rst_cnt_o, 0);

    // Debug pulse in RUN.
    dbg_pulse("dbg1", 1, 1);
    expect_release("dbg1", 16, 24);

    // Debug level held 5 cycles from RUN counts once; hold restarts on last sample.
    dbg_pulse("lvl", 2, 2);
    dbg = 1'b1;
    step(4);
    dbg = 1'b0;
    chk("lvl_cnt_held", m_if.dbg_rst_cnt_o, 2);
    chk("lvl_wb_held", m_if.wb_rst_o, 1);
    step(16);
    chk("lvl_wb_fall", m_if.wb_rst_o, 0);

    // Collision with the WB_UP->RUN edge: debug wins.
    step(7);
    chk("col_run_cpu_pre", m_if.cpu_rst_o, 1);
    dbg_pulse("col_run", 3, 3);
    expect_release("col_run", 16, 24);

    // Collision with the HOLD->WB_UP edge: stays in HOLD, no count.
    dbg_pulse("hold", 4, 3);
    step(15);
    dbg = 1'b1;
    step(1);
    dbg = 1'b0;
    chk("col_hold_wb", m_if.wb_rst_o, 1);
    chk("col_hold_cnt", m_if.dbg_rst_cnt_o, 4);
    $display("txn col_hold: debug on hold-release edge, wb=%0d", m_if.wb_rst_o);
    expect_release("col_hold", 16, 24);

    // Fifth event: the narrow counter stays saturated.
    dbg_pulse("dbg5", 5, 3);
    expect_release("dbg5", 16, 24);

    // Pad reset from RUN clears everything asynchronously.
    rst_n = 1'b0;
    #1;
    chk("pad_wb", m_if.wb_rst_o, 1);
    chk("pad_done", m_if.rst_done_o, 0);
    chk("pad_cnt", m_if.dbg_rst_cnt_o, 0);
    chk("pad_sat_cnt", s_if.dbg_rst_cnt_o, 0);
    #13 rst_n = 1'b1;
    step(22);
    chk("mid_wb_up", m_if.wb_rst_o, 0);
    chk("mid_cpu_up", m_if.cpu_rst_o, 1);

    // 3ns glitch in WB_UP: resets reassert before the next edge.
    #2 rst_n = 1'b0;
    #1;
    chk("glitch_wb", m_if.wb_rst_o, 1);
    chk("glitch_cpu", m_if.cpu_rst_o, 1);
    #2 rst_n = 1'b1;
    $display("txn glitch: pad low 3ns in WB_UP, wb=%0d", m_if.wb_rst_o);

    // Debug held during RESET is ignored; full sequence replays.
    dbg = 1'b1;
    step(2);
    dbg = 1'b0;
    expect_release("replay", 17, 25);
    chk("replay_cnt", m_if.dbg_rst_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
